nonce_range_gen: RTL and testbench
==================================

Name: nonce_range_gen

Overview:
- Parametrised successor to the single-core nonce counter.
- Splits the NONCE_W-bit nonce space into 2^LOG2_NCORE equal, disjoint slices, one per hashing core.
- Steps all slices in lockstep, once per ROUNDS-cycle hash round, using its own round counter instead of an external cycle input.
- Adds job start with resume offset, stall, found-halt, and slice-exhausted reporting. Sits between the job/control FSM and the SHA core array.

Parameters:
- LOG2_NCORE, 0, log2 of core count; NCORE = 2^LOG2_NCORE; must be < NONCE_W.
- NONCE_W, 32, nonce width in bits.
- ROUNDS, 64, clocks per hash round (ROUNDS >= 1); the nonce advances once per round.
- RND_W, 6, round counter width; must satisfy 2^RND_W >= ROUNDS.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- job_start  in  1  1-cycle pulse: load offset and begin a new job.
- start_offset  in  NONCE_W-LOG2_NCORE  per-slice starting count (resume point).
- stall  in  1  freeze round counter and nonce while high.
- found  in  1  any core reports a hit; halt the job.
- nonce_o  out  NCORE*NONCE_W  core i nonce at bits [i*NONCE_W +: NONCE_W].
- offset_o  out  NONCE_W-LOG2_NCORE  current shared slice count.
- round_o  out  RND_W  current round cycle index; 0 means a new nonce is presented.
- busy  out  1  job active (RUN state).
- halted  out  1  job stopped by found.
- exhausted  out  1  slice space fully searched.

Behaviour:
- Constants: CNT_W = NONCE_W-LOG2_NCORE; CNT_MAX = all ones in CNT_W bits.
- nonce_o slice i = {i[LOG2_NCORE-1:0], offset_o}, purely combinational from the offset register. With LOG2_NCORE=0, nonce_o = offset_o.
- Reset, synchronous on rst=1 at the clk edge: state=IDLE, offset_o=0, round_o=0, busy=0, halted=0, exhausted=0. rst dominates all other inputs.
- FSM states: IDLE, RUN, HALT, DONE.
- IDLE:
  - job_start=1 -> RUN next cycle, with offset_o=start_offset and round_o=0.
  - found, stall ignored.
- RUN, evaluated in this priority order:
  - 1. job_start=1: restart. offset_o=start_offset, round_o=0, stay in RUN, clear halted and exhausted.
  - 2. found=1: go to HALT. offset_o and round_o freeze at their current values so software can read the winning offset.
  - 3. stall=1: hold all state.
  - 4. Otherwise round_o increments each cycle.
  - When round_o == ROUNDS-1, round_o wraps to 0 and offset_o increments by 1.
  - If offset_o == CNT_MAX at that wrap, go to DONE instead; offset_o stays CNT_MAX and does not wrap to 0.
- HALT and DONE: hold all state. job_start=1 -> RUN with a fresh load; any other input is ignored.
- Outputs: busy = (state==RUN); halted = (state==HALT); exhausted = (state==DONE). All are registered state decodes.
- Latency:
  - job_start at edge k -> busy=1, round_o=0 and the new nonce are visible after edge k.
  - found at edge k -> halted=1 after edge k; no further increment occurs at or after edge k.
- Simultaneous events:
  - found and round wrap in the same cycle: found wins, no increment.
  - found and job_start in the same cycle: job_start wins.
  - stall and found in the same cycle: found wins.
- ROUNDS=1: offset_o increments every non-stalled RUN cycle; round_o stays 0.
- Arithmetic:
  - All counts are unsigned.
  - offset_o is exactly CNT_W bits wide; the core-index prefix never carries into it.
  - round_o compare is against ROUNDS-1 truncated to RND_W bits.

Decomposition:
- Package nonce_pkg holds: the state enum type (IDLE/RUN/HALT/DONE, 2 bits), a function computing CNT_W from the parameters, and default constants NONCE_W_DEF=32 and ROUNDS_DEF=64.
- One sub-module is natural: round_counter. It is a parametrised RND_W-bit counter with enable, synchronous clear, and a wrap pulse at a programmable terminal value. It is instantiated for the round index; the offset register stays in the parent.
- Add elaboration-time assertions for LOG2_NCORE < NONCE_W and ROUNDS <= 2^RND_W.

Test Plan:
- Reset/load, LOG2_NCORE=2, ROUNDS=64.
  - Stimulus: rst, then job_start with start_offset=0x0000_0005.
  - Required: core0=0x0000_0005, core1=0x4000_0005, core2=0x8000_0005, core3=0xC000_0005, busy=1, round_o=0.
- Stepping.
  - Stimulus: run 64 cycles from offset 5.
  - Required: at cycle 64 offset_o=6 and core3 nonce=0xC000_0006; after 128 cycles offset_o=7.
- Stall.
  - Stimulus: stall=1 for 10 cycles when round_o=30.
  - Required: round_o stays 30 and offset_o is unchanged; the next increment arrives 10 cycles later than without stall.
- Found at wrap.
  - Stimulus: found=1 on the cycle with round_o=63, offset_o=9.
  - Required: halted=1, busy=0, offset_o=9 held indefinitely. A later job_start with offset 0 gives RUN, offset_o=0, halted=0.
- Exhaust, LOG2_NCORE=2, NONCE_W=8, ROUNDS=1.
  - Stimulus: start_offset=0x3E.
  - Required: offset_o goes 0x3E, then 0x3F, then exhausted=1 with offset_o stuck at 0x3F; no wrap to 0.
- Priority.
  - Stimulus: job_start and found in the same cycle while in RUN.
  - Required: restart wins (busy=1, halted=0). rst asserted mid-RUN gives the full reset state next cycle.

Source files
------------

// File: rtl/nonce_pkg.sv
// Shared types and helpers for the sliced nonce generator.
package nonce_pkg;

  localparam int unsigned NONCE_W_DEF = 32;
  localparam int unsigned ROUNDS_DEF  = 64;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2,
    StDone = 2'd3
  } state_e;

  // Width of the per-slice count once the core-index prefix is removed.
  function automatic int unsigned cnt_w(input int unsigned nonce_w,
                                        input int unsigned log2_ncore);
    return nonce_w - log2_ncore;
  endfunction

endpackage

// File: rtl/round_counter.sv
// Width-bit counter with enable, synchronous clear and a wrap pulse at a programmable terminal.
module round_counter #(
  parameter int unsigned Width = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [Width-1:0] term_i,
  output logic [Width-1:0] cnt_o,
  output logic             wrap_o
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             at_term;

  assign at_term = (cnt_q == term_i);
  assign wrap_o  = en_i && at_term;
  assign cnt_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_term ? '0 : cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nonce_range_gen.sv
// Splits the nonce space into per-core slices and steps them once per hash round.
module nonce_range_gen
  import nonce_pkg::*;
#(
  parameter int unsigned LOG2_NCORE = 0,
  parameter int unsigned NONCE_W    = NONCE_W_DEF,
  parameter int unsigned ROUNDS     = ROUNDS_DEF,
  parameter int unsigned RND_W      = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  job_start,
  input  logic [NONCE_W-LOG2_NCORE-1:0]         start_offset,
  input  logic                                  stall,
  input  logic                                  found,
  output logic [(2**LOG2_NCORE)*NONCE_W-1:0]    nonce_o,
  output logic [NONCE_W-LOG2_NCORE-1:0]         offset_o,
  output logic [RND_W-1:0]                      round_o,
  output logic                                  busy,
  output logic                                  halted,
  output logic                                  exhausted
);

  localparam int unsigned CNT_W = cnt_w(NONCE_W, LOG2_NCORE);
  localparam int unsigned NCORE = 2 ** LOG2_NCORE;
  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [RND_W-1:0] RoundTerm = RND_W'(ROUNDS - 1);

  if (LOG2_NCORE >= NONCE_W) begin : g_bad_ncore
    $error("nonce_range_gen: LOG2_NCORE must be less than NONCE_W");
  end
  if (ROUNDS < 1 || ROUNDS > 2 ** RND_W) begin : g_bad_rounds
    $error("nonce_range_gen: ROUNDS must be in 1..2**RND_W");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] offset_q, offset_d;
  logic             rnd_en;
  logic             rnd_wrap;

  // The round index only advances on an undisturbed RUN cycle.
  assign rnd_en = (state_q == StRun) && !job_start && !found && !stall;

  round_counter #(
    .Width (RND_W)
  ) u_round (
    .clk    (clk),
    .rst    (rst),
    .en_i   (rnd_en),
    .clr_i  (job_start),
    .term_i (RoundTerm),
    .cnt_o  (round_o),
    .wrap_o (rnd_wrap)
  );

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    unique case (state_q)
      StRun: begin
        if (job_start) begin
          offset_d = start_offset;
        end else if (found) begin
          state_d = StHalt;
        end else if (rnd_wrap) begin
          // The last slice value is kept rather than wrapping back to zero.
          if (offset_q == CntMax) begin
            state_d = StDone;
          end else begin
            offset_d = offset_q + CNT_W'(1);
          end
        end
      end
      StIdle, StHalt, StDone: begin
        if (job_start) begin
          state_d  = StRun;
          offset_d = start_offset;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
    end
  end

  for (genvar i = 0; i < NCORE; i++) begin : g_core
    assign nonce_o[i*NONCE_W +: NONCE_W] = (NONCE_W'(i) << CNT_W) | NONCE_W'(offset_q);
  end

  assign offset_o  = offset_q;
  assign busy      = (state_q == StRun);
  assign halted    = (state_q == StHalt);
  assign exhausted = (state_q == StDone);

endmodule

// File: tb/tb_nonce_range_gen.sv
// Checks two nonce_range_gen configurations against a behavioural model plus literal pins.
module tb_nonce_range_gen;

  localparam int MIdle = 0;
  localparam int MRun  = 1;
  localparam int MHalt = 2;
  localparam int MDone = 3;

  logic clk;
  int   checks   = 0;
  int   failures = 0;

  // Configuration 0: 4 cores, 32-bit nonce, 64 rounds.
  logic         rst0, js0, st0, fd0;
  logic [29:0]  so0, o0;
  logic [127:0] n0;
  logic [5:0]   r0;
  logic         b0, h0, e0;

  // Configuration 1: 4 cores, 8-bit nonce, 1 round.
  logic         rst1, js1, st1, fd1;
  logic [5:0]   so1, o1;
  logic [31:0]  n1;
  logic [5:0]   r1;
  logic         b1, h1, e1;

  nonce_range_gen #(
    .LOG2_NCORE (2),
    .NONCE_W    (32),
    .ROUNDS     (64),
    .RND_W      (6)
  ) dut0 (
    .clk          (clk),
    .rst          (rst0),
    .job_start    (js0),
    .start_offset (so0),
    .stall        (st0),
    .found        (fd0),
    .nonce_o      (n0),
    .offset_o     (o0),
    .round_o      (r0),
    .busy         (b0),
    .halted       (h0),
    .exhausted    (e0)
  );

  nonce_range_gen #(
    .LOG2_NCORE (2),
    .NONCE_W    (8),
    .ROUNDS     (1),
    .RND_W      (6)
  ) dut1 (
    .clk          (clk),
    .rst          (rst1),
    .job_start    (js1),
    .start_offset (so1),
    .stall        (st1),
    .found        (fd1),
    .nonce_o      (n1),
    .offset_o     (o1),
    .round_o      (r1),
    .busy         (b1),
    .halted       (h1),
    .exhausted    (e1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: job state, shared slice count and round index per configuration.
  int          m_st [2];
  logic [31:0] m_off[2];
  int          m_rnd[2];
  int          cntw [2] = '{30, 6};
  int          rnds [2] = '{64, 1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int d, input logic rst, input logic js, input logic [31:0] so,
                      input logic stl, input logic fnd);
    logic [31:0] cmax;
    cmax = (32'd1 << cntw[d]) - 32'd1;
    if (rst) begin
      m_st[d] = MIdle; m_off[d] = 0; m_rnd[d] = 0;
    end else if (js) begin
      m_st[d] = MRun; m_off[d] = so; m_rnd[d] = 0;
    end else if (m_st[d] == MRun) begin
      if (fnd) begin
        m_st[d] = MHalt;
      end else if (!stl) begin
        if (m_rnd[d] == rnds[d] - 1) begin
          m_rnd[d] = 0;
          if (m_off[d] == cmax) m_st[d] = MDone;
          else m_off[d] = m_off[d] + 1;
        end else begin
          m_rnd[d] = m_rnd[d] + 1;
        end
      end
    end
  endtask

  task automatic compare();
    chk("off0", 64'(o0), 64'(m_off[0]));
    chk("rnd0", 64'(r0), 64'(m_rnd[0]));
    chk("busy0", 64'(b0), 64'(m_st[0] == MRun));
    chk("halt0", 64'(h0), 64'(m_st[0] == MHalt));
    chk("exh0", 64'(e0), 64'(m_st[0] == MDone));
    for (int i = 0; i < 4; i++)
      chk("nonce0", 64'(n0[i*32 +: 32]), 64'((32'(i) << 30) | m_off[0]));
    chk("off1", 64'(o1), 64'(m_off[1]));
    chk("rnd1", 64'(r1), 64'(m_rnd[1]));
    chk("busy1", 64'(b1), 64'(m_st[1] == MRun));
    chk("halt1", 64'(h1), 64'(m_st[1] == MHalt));
    chk("exh1", 64'(e1), 64'(m_st[1] == MDone));
    for (int i = 0; i < 4; i++)
      chk("nonce1", 64'(n1[i*8 +: 8]), 64'(((32'(i) << 6) | m_off[1]) & 32'hFF));
  endtask

  task automatic tick();
    @(posedge clk);
    step(0, rst0, js0, 32'(so0), st0, fd0);
    step(1, rst1, js1, 32'(so1), st1, fd1);
    @(negedge clk);
    compare();
  endtask

  initial begin
    m_st  = '{MIdle, MIdle};
    m_off = '{32'd0, 32'd0};
    m_rnd = '{0, 0};
    rst0 = 1'b1; js0 = 1'b0; so0 = '0; st0 = 1'b0; fd0 = 1'b0;
    rst1 = 1'b1; js1 = 1'b0; so1 = '0; st1 = 1'b0; fd1 = 1'b0;
    tick();
    chk("reset_off", 64'(o0), 64'd0);
    chk("reset_busy", 64'(b0), 64'd0);
    rst0 = 1'b0; rst1 = 1'b0;

    // Load offset 5 on four cores.
    js0 = 1'b1; so0 = 30'd5;
    tick();
    js0 = 1'b0;
    chk("load_core0", 64'(n0[31:0]),   64'h0000_0005);
    chk("load_core1", 64'(n0[63:32]),  64'h4000_0005);
    chk("load_core2", 64'(n0[95:64]),  64'h8000_0005);
    chk("load_core3", 64'(n0[127:96]), 64'hC000_0005);
    chk("load_busy", 64'(b0), 64'd1);
    chk("load_round", 64'(r0), 64'd0);

    repeat (64) tick();
    chk("step1_off", 64'(o0), 64'd6);
    chk("step1_core3", 64'(n0[127:96]), 64'hC000_0006);
    repeat (64) tick();
    chk("step2_off", 64'(o0), 64'd7);

    repeat (30) tick();
    chk("pre_stall_round", 64'(r0), 64'd30);
    st0 = 1'b1;
    repeat (10) tick();
    st0 = 1'b0;
    chk("stall_round", 64'(r0), 64'd30);
    chk("stall_off", 64'(o0), 64'd7);
    repeat (33) tick();
    chk("stall_late_off", 64'(o0), 64'd7);
    chk("stall_late_round", 64'(r0), 64'd63);
    tick();
    chk("stall_next_off", 64'(o0), 64'd8);

    // Found on the wrap cycle at offset 9.
    repeat (127) tick();
    chk("pre_found_off", 64'(o0), 64'd9);
    chk("pre_found_round", 64'(r0), 64'd63);
    fd0 = 1'b1;
    tick();
    fd0 = 1'b0;
    chk("found_halt", 64'(h0), 64'd1);
    chk("found_busy", 64'(b0), 64'd0);
    chk("found_off", 64'(o0), 64'd9);
    repeat (50) begin
      st0 = ($urandom_range(0, 1) == 0);
      fd0 = ($urandom_range(0, 1) == 0);
      tick();
    end
    st0 = 1'b0; fd0 = 1'b0;
    chk("halt_hold_off", 64'(o0), 64'd9);
    chk("halt_hold", 64'(h0), 64'd1);
    js0 = 1'b1; so0 = 30'd0;
    tick();
    js0 = 1'b0;
    chk("restart_busy", 64'(b0), 64'd1);
    chk("restart_off", 64'(o0), 64'd0);
    chk("restart_halt", 64'(h0), 64'd0);

    // job_start beats found; rst mid-run.
    repeat (5) tick();
    js0 = 1'b1; fd0 = 1'b1; so0 = 30'h123;
    tick();
    js0 = 1'b0; fd0 = 1'b0;
    chk("prio_busy", 64'(b0), 64'd1);
    chk("prio_halt", 64'(h0), 64'd0);
    chk("prio_off", 64'(o0), 64'h123);
    repeat (7) tick();
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    chk("rst_off", 64'(o0), 64'd0);
    chk("rst_round", 64'(r0), 64'd0);
    chk("rst_busy", 64'(b0), 64'd0);

    // Exhaust the 6-bit slice space with one-cycle rounds.
    js1 = 1'b1; so1 = 6'h3E;
    tick();
    js1 = 1'b0;
    chk("exh_load", 64'(o1), 64'h3E);
    tick();
    chk("exh_step", 64'(o1), 64'h3F);
    chk("exh_notyet", 64'(e1), 64'd0);
    tick();
    chk("exh_done", 64'(e1), 64'd1);
    chk("exh_off", 64'(o1), 64'h3F);
    repeat (5) tick();
    chk("exh_hold", 64'(o1), 64'h3F);
    chk("exh_core3", 64'(n1[31:24]), 64'hFF);

    // Randomised phase.
    for (int c = 0; c < 3000; c++) begin
      rst0 = ($urandom_range(0, 199) == 0);
      js0  = ($urandom_range(0, 49) == 0);
      so0  = ($urandom_range(0, 1) == 0) ? 30'h3FFF_FFFF - 30'($urandom_range(0, 3))
                                           : 30'($urandom);
      st0  = ($urandom_range(0, 3) == 0);
      fd0  = ($urandom_range(0, 39) == 0);
      rst1 = ($urandom_range(0, 199) == 0);
      js1  = ($urandom_range(0, 19) == 0);
      so1  = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(56, 63)) : 6'($urandom);
      st1  = ($urandom_range(0, 3) == 0);
      fd1  = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
